// File: rtl/la_ioring_cfgtx.sv
// IO-ring segment config transmitter: shifts a captured pad-config
// word MSB-first down the pad chain, then pulses a common latch strobe.
module la_ioring_cfgtx #(
  parameter int NPADS  = 4,
  parameter int CFGW   = 8,
  parameter int CLKDIV = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [NPADS*CFGW-1:0] cfg_data,
  output logic                  ring_sdo,
  output logic                  ring_stb,
  output logic                  ring_latch,
  output logic                  busy,
  output logic                  done
);

  localparam int NBITS = NPADS * CFGW;
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t           state, state_nxt;
  logic [NBITS-1:0] sreg, sreg_nxt, shl;
  logic [BW-1:0]    bitcnt, bitcnt_nxt;
  logic [DW-1:0]    divcnt, divcnt_nxt;
  logic             sdo_nxt, done_nxt;
  logic             accept, bit_end;

  assign shl     = sreg << 1;
  assign accept  = cfg_valid && (state == IDLE);
  assign bit_end = (state == SHIFT) && (divcnt == DIV_LAST);

  assign cfg_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign ring_stb   = bit_end;
  assign ring_latch = (state == LATCH);

  always_comb begin
    state_nxt  = state;
    sreg_nxt   = sreg;
    bitcnt_nxt = bitcnt;
    divcnt_nxt = divcnt;
    sdo_nxt    = ring_sdo;
    done_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt  = SHIFT;
          sreg_nxt   = cfg_data;
          bitcnt_nxt = '0;
          divcnt_nxt = '0;
          sdo_nxt    = cfg_data[NBITS-1];
        end
      end
      SHIFT: begin
        if (!bit_end) begin
          divcnt_nxt = divcnt + DW'(1);
        end else if (bitcnt == BIT_LAST) begin
          // chain is full: park the data line low for the latch cycle
          state_nxt = LATCH;
          sdo_nxt   = 1'b0;
        end else begin
          sreg_nxt   = shl;
          sdo_nxt    = shl[NBITS-1];
          bitcnt_nxt = bitcnt + BW'(1);
          divcnt_nxt = '0;
        end
      end
      LATCH: begin
        state_nxt = IDLE;
        sdo_nxt   = 1'b0;
        done_nxt  = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        sdo_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sreg     <= '0;
      bitcnt   <= '0;
      divcnt   <= '0;
      ring_sdo <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sreg     <= sreg_nxt;
      bitcnt   <= bitcnt_nxt;
      divcnt   <= divcnt_nxt;
      ring_sdo <= sdo_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_la_ioring_cfgtx.sv
// Directed bench for la_ioring_cfgtx: three parameter sets share one
// clock; each transfer is traced per cycle and compared to fixed vectors.
module tb_la_ioring_cfgtx;

  logic       clk;
  logic       rst;
  logic [2:0] vld, rdy, sdo, stb, lat, bsy, dne;
  logic [7:0] da, db;
  logic [0:0] dc;

  logic [63:0] t_sdo, t_stb, t_lat, t_done, t_busy, t_rdy;
  int n_chk, n_fail;

  la_ioring_cfgtx #(.NPADS(2), .CFGW(4), .CLKDIV(2)) u_a (
    .clk(clk), .reset(rst), .cfg_valid(vld[0]), .cfg_ready(rdy[0]),
    .cfg_data(da), .ring_sdo(sdo[0]), .ring_stb(stb[0]),
    .ring_latch(lat[0]), .busy(bsy[0]), .done(dne[0])
  );

  la_ioring_cfgtx #(.NPADS(2), .CFGW(4), .CLKDIV(1)) u_b (
    .clk(clk), .reset(rst), .cfg_valid(vld[1]), .cfg_ready(rdy[1]),
    .cfg_data(db), .ring_sdo(sdo[1]), .ring_stb(stb[1]),
    .ring_latch(lat[1]), .busy(bsy[1]), .done(dne[1])
  );

  la_ioring_cfgtx #(.NPADS(1), .CFGW(1), .CLKDIV(3)) u_c (
    .clk(clk), .reset(rst), .cfg_valid(vld[2]), .cfg_ready(rdy[2]),
    .cfg_data(dc), .ring_sdo(sdo[2]), .ring_stb(stb[2]),
    .ring_latch(lat[2]), .busy(bsy[2]), .done(dne[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int s, input logic v, input logic [7:0] d);
    case (s)
      0: begin vld[0] = v; da = d; end
      1: begin vld[1] = v; db = d; end
      default: begin vld[2] = v; dc = d[0]; end
    endcase
  endtask

  // Present d, then trace n cycles after the acceptance edge (cycle 1
  // ends up in bit n-1). d2 replaces d right after acceptance.
  task automatic xfer(input int s, input logic [7:0] d,
                      input logic [7:0] d2, input int n, input bit keep,
                      input int rst_k, input int pulse_k);
    t_sdo = '0; t_stb = '0; t_lat = '0;
    t_done = '0; t_busy = '0; t_rdy = '0;
    @(negedge clk);
    chk("pre_ready", 64'(rdy[s]), 64'd1);
    set_in(s, 1'b1, d);
    @(posedge clk);
    #1;
    set_in(s, keep, d2);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      t_sdo  = {t_sdo[62:0], sdo[s]};
      t_stb  = {t_stb[62:0], stb[s]};
      t_lat  = {t_lat[62:0], lat[s]};
      t_done = {t_done[62:0], dne[s]};
      t_busy = {t_busy[62:0], bsy[s]};
      t_rdy  = {t_rdy[62:0], rdy[s]};
      if (k == rst_k) rst = 1'b1;
      if (k == rst_k + 1) rst = 1'b0;
      if (k == pulse_k) set_in(s, 1'b1, 8'h5A);
      if (k == pulse_k + 2) set_in(s, 1'b0, 8'h5A);
      if (keep && k == 19) set_in(s, 1'b0, d2);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    vld = '0;
    da = '0;
    db = '0;
    dc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vld = 3'b111;
    @(negedge clk);
    chk("rst_a", 64'({rdy[0], sdo[0], stb[0], lat[0], bsy[0], dne[0]}),
        64'b100000);
    chk("rst_b", 64'({rdy[1], sdo[1], stb[1], lat[1], bsy[1], dne[1]}),
        64'b100000);
    chk("rst_c", 64'({rdy[2], sdo[2], stb[2], lat[2], bsy[2], dne[2]}),
        64'b100000);
    vld = '0;
    rst = 1'b0;

    // basic A5, CLKDIV=2
    xfer(0, 8'hA5, 8'h5A, 18, 1'b0, -10, -10);
    chk("a5_sdo", t_sdo, 64'b110011000011001100);
    chk("a5_stb", t_stb, 64'b010101010101010100);
    chk("a5_lat", t_lat, 64'b000000000000000010);
    chk("a5_done", t_done, 64'b000000000000000001);
    chk("a5_busy", t_busy, 64'b111111111111111110);
    chk("a5_rdy", t_rdy, 64'b000000000000000001);

    // CLKDIV=1, 3C
    xfer(1, 8'h3C, 8'hC3, 10, 1'b0, -10, -10);
    chk("3c_sdo", t_sdo, 64'b0011110000);
    chk("3c_stb", t_stb, 64'b1111111100);
    chk("3c_lat", t_lat, 64'b0000000010);
    chk("3c_done", t_done, 64'b0000000001);

    // single-bit chain, CLKDIV=3
    xfer(2, 8'h01, 8'h00, 5, 1'b0, -10, -10);
    chk("n1_sdo", t_sdo, 64'b11100);
    chk("n1_stb", t_stb, 64'b00100);
    chk("n1_lat", t_lat, 64'b00010);
    chk("n1_done", t_done, 64'b00001);

    // back-to-back FF then 00 with valid held
    xfer(0, 8'hFF, 8'h00, 36, 1'b1, -10, -10);
    chk("b2b_sdo", t_sdo, 64'hFFFF << 20);
    chk("b2b_lat", t_lat, (64'd1 << 19) | 64'd2);
    chk("b2b_nlat", 64'($countones(t_lat)), 64'd2);
    chk("b2b_nstb", 64'($countones(t_stb)), 64'd16);
    chk("b2b_done", t_done, (64'd1 << 18) | 64'd1);
    chk("b2b_rdy", t_rdy, (64'd1 << 18) | 64'd1);

    // reset asserted in cycle 7 of an A5 transfer
    xfer(0, 8'hA5, 8'h5A, 20, 1'b0, 7, -10);
    chk("rst_stb", t_stb, 64'b01010100000000000000);
    chk("rst_lat", t_lat, 64'd0);
    chk("rst_done", t_done, 64'd0);
    chk("rst_busy", t_busy, 64'b11111110000000000000);
    chk("rst_rdy", t_rdy, 64'b00000001111111111111);
    xfer(0, 8'h81, 8'h7E, 18, 1'b0, -10, -10);
    chk("81_sdo", t_sdo, 64'b110000000000001100);
    chk("81_lat", t_lat, 64'b000000000000000010);

    // valid pulsed mid-shift with other data
    xfer(0, 8'hA5, 8'h00, 18, 1'b0, -10, 5);
    chk("hold_rdy", t_rdy, 64'b000000000000000001);
    chk("hold_sdo", t_sdo, 64'b110011000011001100);
    chk("hold_lat", t_lat, 64'b000000000000000010);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
